decoder_scan_ctrl: RTL and testbench

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

---
 rtl/decoder_scan_pkg.sv | 36 +++
 rtl/scan_tick_cnt.sv | 27 ++
 rtl/decoder_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the 2-to-4 decoder scan controller.
// Channel search helper is used by the optional SCAN_SKIP_EN build.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_e;

    localparam int CNT_W            = 8;
    localparam int DEF_ACTIVE_TICKS = 4;
    localparam int DEF_BLANK_TICKS  = 2;

    typedef struct packed {
        logic       found;
        logic [1:0] ch;
    } chsel_t;

    // First unmasked channel strictly after cur, cyclically (cur itself last).
    function automatic chsel_t next_chan(input logic [1:0] cur,
                                         input logic [3:0] mask);
        chsel_t     r;
        logic [1:0] c;
        r = '0;
        for (int i = 1; i <= 4; i++) begin
            c = cur + 2'(i);
            if (!r.found && !mask[c]) begin
                r.found = 1'b1;
                r.ch    = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_tick_cnt.sv
// Reloadable 8-bit down counter; expire_o is high while the count is zero.
// Holds at zero until the next load.
module scan_tick_cnt
    import decoder_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] count_q;

    assign expire_o = (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (!expire_o) begin
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving select/enable of a 2-to-4 decoder.
// Define SCAN_SKIP_EN to add skip_mask[3:0] channel skipping.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int ACTIVE_TICKS = DEF_ACTIVE_TICKS,
    parameter int BLANK_TICKS  = DEF_BLANK_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
`ifdef SCAN_SKIP_EN
    input  logic [3:0] skip_mask,
`endif
    output logic       a,
    output logic       b,
    output logic       e,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] A_LOAD = CNT_W'(ACTIVE_TICKS - 1);
    localparam logic [CNT_W-1:0] B_LOAD =
        CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    state_e           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic             e_q, busy_q, fd_q, fd_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expire;
    logic [3:0]       mask;
    chsel_t           nxt, first;

`ifdef SCAN_SKIP_EN
    assign mask = skip_mask;
`else
    assign mask = '0;
`endif

    assign nxt   = next_chan(ch_q, mask);
    assign first = next_chan(2'd3, mask);

    scan_tick_cnt u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .load_val_i(load_val),
        .expire_o  (expire)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        fd_d     = 1'b0;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            IDLE: begin
                if (run && first.found) begin
                    state_d  = ACTIVE;
                    ch_d     = first.ch;
                    load     = 1'b1;
                    load_val = A_LOAD;
                end
            end
            ACTIVE: begin
                if (expire) begin
                    load = 1'b1;
                    if (run && nxt.found) begin
                        ch_d = nxt.ch;
                        // Advancing to an index not above the current one means channel 3 was passed.
                        fd_d = (nxt.ch <= ch_q);
                        if (BLANK_TICKS == 0) begin
                            state_d  = ACTIVE;
                            load_val = A_LOAD;
                        end else begin
                            state_d  = BLANK;
                            load_val = B_LOAD;
                        end
                    end else begin
                        state_d = IDLE;
                        ch_d    = 2'd0;
                    end
                end
            end
            BLANK: begin
                if (!run) begin
                    state_d = IDLE;
                    ch_d    = 2'd0;
                    load    = 1'b1;
                end else if (expire) begin
                    state_d  = ACTIVE;
                    load     = 1'b1;
                    load_val = A_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = 2'd0;
                load    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            e_q     <= (state_d == ACTIVE);
            busy_q  <= (state_d != IDLE);
            fd_q    <= fd_d;
        end
    end

    assign a          = ch_q[1];
    assign b          = ch_q[0];
    assign e          = e_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench: slot-position reference model vs two DUT configurations.
// Optional SCAN_SKIP_EN sections exercise channel skipping.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run0, run1;
    logic [3:0] skip;
    logic       a0, b0, e0, busy0, fd0;
    logic       a1, b1, e1, busy1, fd1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit idle;
        int ch;
        int t;
    } mst_t;

    mst_t       s0, s1;
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    decoder_scan_ctrl #(.ACTIVE_TICKS(4), .BLANK_TICKS(2)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run0),
`ifdef SCAN_SKIP_EN
        .skip_mask (skip),
`endif
        .a         (a0),
        .b         (b0),
        .e         (e0),
        .busy      (busy0),
        .frame_done(fd0)
    );

    decoder_scan_ctrl #(.ACTIVE_TICKS(1), .BLANK_TICKS(0)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run1),
`ifdef SCAN_SKIP_EN
        .skip_mask (4'b0000),
`endif
        .a         (a1),
        .b         (b1),
        .e         (e1),
        .busy      (busy1),
        .frame_done(fd1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [4:0] act,
                                input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {a,b,e,busy,fd}=%b want %b at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    // Each channel owns a slot of at+bt cycles: positions < at are lit.
    function automatic logic [4:0] model_step(input int at, input int bt,
                                              input bit rv, input bit run,
                                              input logic [3:0] m,
                                              inout mst_t s);
        bit         fd;
        bit         found;
        logic [1:0] ab;
        fd = 1'b0;
        if (!rv) begin
            s.idle = 1'b1; s.ch = 0; s.t = 0;
        end else if (s.idle) begin
            if (run) begin
                for (int k = 0; k < 4; k++) begin
                    if (s.idle && !m[k]) begin
                        s.idle = 1'b0; s.ch = k; s.t = 0;
                    end
                end
            end
        end else if (s.t < at - 1) begin
            s.t++;
        end else if (!run) begin
            s.idle = 1'b1; s.ch = 0; s.t = 0;
        end else if (s.t == at - 1) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && !m[(s.ch + k) % 4]) begin
                    found = 1'b1;
                    fd    = (s.ch + k >= 4);
                    s.ch  = (s.ch + k) % 4;
                end
            end
            if (!found) begin
                s.idle = 1'b1; s.ch = 0; s.t = 0;
            end else begin
                s.t = (bt == 0) ? 0 : at;
            end
        end else begin
            s.t++;
            if (s.t == at + bt) s.t = 0;
        end
        ab = s.idle ? 2'b00 : 2'(s.ch);
        return {ab, (!s.idle && s.t < at), !s.idle, fd};
    endfunction

    task automatic step(input bit rv, input bit r0, input bit r1,
                        input logic [3:0] m);
        @(negedge clk);
        rst_n = rv;
        run0  = r0;
        run1  = r1;
        skip  = m;
`ifdef SCAN_SKIP_EN
        q0.push_back(model_step(4, 2, rv, r0, m, s0));
`else
        q0.push_back(model_step(4, 2, rv, r0, 4'b0000, s0));
`endif
        q1.push_back(model_step(1, 0, rv, r1, 4'b0000, s1));
    endtask

    task automatic reset_models();
        s0 = '{1'b1, 0, 0};
        s1 = '{1'b1, 0, 0};
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst0", {a0, b0, e0, busy0, fd0}, 5'b00000);
        chk("async_rst1", {a1, b1, e1, busy1, fd1}, 5'b00000);
        reset_models();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0)
                chk("dut0", {a0, b0, e0, busy0, fd0}, q0.pop_front());
            if (q1.size() > 0)
                chk("dut1", {a1, b1, e1, busy1, fd1}, q1.pop_front());
        end
    end

    initial begin
        bit         r0, r1;
        logic [3:0] m;
        rst_n = 1'b1;
        run0  = 1'b0;
        run1  = 1'b0;
        skip  = 4'b0000;
        reset_models();
        #2 rst_n = 1'b0;
        #1;
        chk("reset0", {a0, b0, e0, busy0, fd0}, 5'b00000);
        chk("reset1", {a1, b1, e1, busy1, fd1}, 5'b00000);
        repeat (2) step(1'b0, 1'b1, 1'b1, 4'b0000);

        repeat (75) step(1'b1, 1'b1, 1'b1, 4'b0000);

        for (int i = 0; i < 40 && !(!s0.idle && s0.ch == 2 && s0.t == 1); i++)
            step(1'b1, 1'b1, 1'b1, 4'b0000);
        repeat (6) step(1'b1, 1'b0, 1'b1, 4'b0000);

        for (int i = 0; i < 30 && !(!s0.idle && s0.t >= 4); i++)
            step(1'b1, 1'b1, 1'b1, 4'b0000);
        async_reset();
        repeat (2) step(1'b0, 1'b1, 1'b1, 4'b0000);
        repeat (30) step(1'b1, 1'b1, 1'b1, 4'b0000);

`ifdef SCAN_SKIP_EN
        repeat (60) step(1'b1, 1'b1, 1'b1, 4'b0101);
        repeat (12) step(1'b1, 1'b1, 1'b1, 4'b1111);
        repeat (20) step(1'b1, 1'b1, 1'b1, 4'b1110);
`endif

        r0 = 1'b1;
        r1 = 1'b1;
        m  = 4'b0000;
        repeat (400) begin
            if ($urandom_range(0, 9) == 0) r0 = ~r0;
            if ($urandom_range(0, 9) == 0) r1 = ~r1;
`ifdef SCAN_SKIP_EN
            if ($urandom_range(0, 29) == 0) m = 4'($urandom_range(0, 15));
`endif
            step(1'b1, r0, r1, m);
        end

        @(posedge clk);
        #3;
        chk("drain", 5'(q0.size() + q1.size()), 5'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
